// File: rtl/fpadd_share_arb.sv
// Round-robin arbiter/sequencer sharing one multi-cycle fpadd unit among NREQ requesters.
// Optional WAIT watchdog enabled by defining FPADD_ARB_TIMEOUT_EN.
module fpadd_share_arb #(
    parameter int NREQ           = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [NREQ*32-1:0]  req_a_i,
    input  logic [NREQ*32-1:0]  req_b_i,
    output logic [NREQ-1:0]     req_ready_o,
    output logic                rsp_valid_o,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic [31:0]         rsp_sum_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic                fp_start_o,
    output logic [31:0]         fp_a_o,
    output logic [31:0]         fp_b_o,
    input  logic [31:0]         fp_sum_i,
    input  logic                fp_done_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [ID_W-1:0] last_q;
    logic            fp_start_q;
    logic [31:0]     fp_a_q;
    logic [31:0]     fp_b_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [31:0]     rsp_sum_q;
    logic            busy_q;

    logic [31:0]     a_slice [NREQ];
    logic [31:0]     b_slice [NREQ];
    logic [NREQ-1:0] above_last;
    logic [NREQ-1:0] upper_req;
    logic [NREQ-1:0] pick_src;
    logic [NREQ-1:0] grant_oh;
    logic [ID_W-1:0] grant_idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign a_slice[gi]    = req_a_i[32*gi +: 32];
        assign b_slice[gi]    = req_b_i[32*gi +: 32];
        assign above_last[gi] = (gi > int'(last_q));
    end

    // Requests strictly above the pointer win; otherwise wrap to the lowest valid index.
    assign upper_req = req_valid_i & above_last;
    assign pick_src  = (|upper_req) ? upper_req : req_valid_i;
    assign grant_oh  = pick_src & (~pick_src + NREQ'(1));

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                grant_idx = grant_idx | ID_W'(i);
            end
        end
    end

    assign req_ready_o = (state_q == S_IDLE) ? grant_oh : '0;

`ifdef FPADD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             rsp_err_q;
    logic             timeout_hit;

    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            last_q      <= ID_W'(NREQ - 1);
            fp_start_q  <= 1'b0;
            fp_a_q      <= '0;
            fp_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            busy_q      <= 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            fp_start_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        fp_a_q     <= a_slice[grant_idx];
                        fp_b_q     <= b_slice[grant_idx];
                        rsp_id_q   <= grant_idx;
                        last_q     <= grant_idx;
                        fp_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // fp_done may still be stale here; it is first sampled in WAIT.
`ifdef FPADD_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fp_done_i) begin
                        rsp_sum_q   <= fp_sum_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
`ifdef FPADD_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_sum_q   <= 32'h7FC0_0000;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + CNT_W'(1);
`endif
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fp_start_o  = fp_start_q;
    assign fp_a_o      = fp_a_q;
    assign fp_b_o      = fp_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign busy_o      = busy_q;

endmodule
